// File: rtl/adc_trn_pkg.sv
// Shared constants and types for the ADC link trainer: FSM state codes,
// ADC test-pattern selects and the pattern-checker mode.
package adc_trn_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE     = 4'd0;
   localparam state_t ST_TAP_LD   = 4'd1;
   localparam state_t ST_SETTLE_W = 4'd2;
   localparam state_t ST_ALIGN    = 4'd3;
   localparam state_t ST_SCAN_CHK = 4'd4;
   localparam state_t ST_CENTER   = 4'd5;
   localparam state_t ST_RAMP_CHK = 4'd6;
   localparam state_t ST_DONE     = 4'd7;
   localparam state_t ST_FAIL     = 4'd8;

   localparam logic [3:0] PAT_OFF  = 4'd0;
   localparam logic [3:0] PAT_RAMP = 4'd1;
   localparam logic [3:0] PAT_ALT  = 4'd2;

   localparam logic [15:0] ALT_P0 = 16'h5555;
   localparam logic [15:0] ALT_P1 = 16'hAAAA;

   typedef enum logic {CHK_ALT, CHK_RAMP} chk_mode_t;

endpackage

// File: rtl/adc_link_trainer_if.sv
// Signal bundle between the trainer, the ADC configuration path and the
// deserializer. dat_*_i are sampled only in cycles where dat_vld_i=1.
interface adc_link_trainer_if #(
   parameter int DW    = 16,
   parameter int DLY_W = 5
);
   import adc_trn_pkg::*;

   logic             start_i;
   logic [DW-1:0]    dat_a_i;
   logic [DW-1:0]    dat_b_i;
   logic             dat_vld_i;
   logic [3:0]       pat_sel_o;
   logic             bitslip_o;
   logic             dly_ld_o;
   logic [DLY_W-1:0] dly_val_o;
   logic             busy_o;
   logic             locked_o;
   logic             fail_o;
   logic [DLY_W-1:0] tap_o;
   state_t           dbg_state;

   modport master (
      input  start_i, dat_a_i, dat_b_i, dat_vld_i,
      output pat_sel_o, bitslip_o, dly_ld_o, dly_val_o, busy_o, locked_o,
             fail_o, tap_o, dbg_state
   );

   modport slave (
      output start_i, dat_a_i, dat_b_i, dat_vld_i,
      input  pat_sel_o, bitslip_o, dly_ld_o, dly_val_o, busy_o, locked_o,
             fail_o, tap_o, dbg_state
   );

endinterface

// File: rtl/adc_pat_chk.sv
// Per-channel word checker: counts consecutive good valid words (alternation
// or ramp) after a reference word; err flags a bad valid word in that cycle.
module adc_pat_chk
   import adc_trn_pkg::*;
#(
   parameter int DW    = 16,
   parameter int CHK_N = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  chk_mode_t     mode,
   input  logic [DW-1:0] data,
   input  logic          valid,
   output logic          pass,
   output logic          err
);
   localparam int CW = $clog2(CHK_N + 1);

   logic [DW-1:0] prev;
   logic          has_prev;
   logic [CW-1:0] cnt;
   logic          good;

   always_comb begin
      good = 1'b0;
      if (mode == CHK_ALT)
         good = ((data == DW'(ALT_P0)) || (data == DW'(ALT_P1))) && (data != prev);
      else
         good = (data == prev + DW'(1));
   end

   assign err  = valid && has_prev && !clear && !good;
   assign pass = (cnt == CW'(CHK_N));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev     <= '0;
         has_prev <= 1'b0;
         cnt      <= '0;
      end else if (clear) begin
         has_prev <= 1'b0;
         cnt      <= '0;
      end else if (valid) begin
         // the first valid word after a clear only seeds prev
         prev     <= data;
         has_prev <= 1'b1;
         if (has_prev) begin
            if (!good)
               cnt <= '0;
            else if (!pass)
               cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/adc_link_trainer.sv
// Link training sequencer: scans delay taps with the alternation pattern,
// word-aligns via bitslip, centres on the widest good run, then ramp-checks.
module adc_link_trainer
   import adc_trn_pkg::*;
#(
   parameter int DW     = 16,
   parameter int DLY_W  = 5,
   parameter int SLIP_N = 8,
   parameter int SETTLE = 16,
   parameter int CHK_N  = 64
) (
   input logic                  clk_i,
   input logic                  rstn_i,
   adc_link_trainer_if.master   bus
);
   localparam int LW = DLY_W + 1;
   localparam int SW = $clog2(SLIP_N + 1);
   localparam int TW = $clog2(SETTLE + 1);
   localparam logic [DLY_W-1:0] TAP_MAX = '1;

   state_t           state, ret_state;
   logic [DLY_W-1:0] tap, cur_start, best_start, tap_out, dly_val;
   logic [LW-1:0]    cur_len, best_len;
   logic [SW-1:0]    slip_cnt;
   logic [TW-1:0]    settle_cnt;
   logic             tap_good, at_center;
   logic [3:0]       pat_sel;
   logic             dly_ld, bitslip, busy, locked, fail;

   logic             pass_a, pass_b, err_a, err_b, pass_all, err_any, chk_clear;
   chk_mode_t        chk_mode;
   logic [DLY_W-1:0] scan_start, fin_start, center_tap;
   logic [LW-1:0]    scan_len, fin_len, half;

   assign chk_clear = !((state == ST_ALIGN) || (state == ST_RAMP_CHK));
   assign chk_mode  = (state == ST_RAMP_CHK) ? CHK_RAMP : CHK_ALT;
   assign pass_all  = pass_a && pass_b;
   assign err_any   = err_a || err_b;

   adc_pat_chk #(.DW(DW), .CHK_N(CHK_N)) u_chk_a (
      .clk(clk_i), .rst_n(rstn_i), .clear(chk_clear), .mode(chk_mode),
      .data(bus.dat_a_i), .valid(bus.dat_vld_i), .pass(pass_a), .err(err_a)
   );

   adc_pat_chk #(.DW(DW), .CHK_N(CHK_N)) u_chk_b (
      .clk(clk_i), .rst_n(rstn_i), .clear(chk_clear), .mode(chk_mode),
      .data(bus.dat_b_i), .valid(bus.dat_vld_i), .pass(pass_b), .err(err_b)
   );

   // Run bookkeeping for the tap just judged; at the last tap the open run
   // is folded into best. Strict > keeps the earlier of equal runs.
   always_comb begin
      scan_len   = cur_len;
      scan_start = cur_start;
      fin_len    = best_len;
      fin_start  = best_start;
      if (tap_good) begin
         scan_len = cur_len + LW'(1);
         if (cur_len == '0)
            scan_start = tap;
      end else begin
         if (cur_len > best_len) begin
            fin_len   = cur_len;
            fin_start = cur_start;
         end
         scan_len = '0;
      end
      if ((tap == TAP_MAX) && (scan_len > fin_len)) begin
         fin_len   = scan_len;
         fin_start = scan_start;
      end
   end

   assign half       = (best_len - LW'(1)) >> 1;
   assign center_tap = best_start + half[DLY_W-1:0];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state      <= ST_IDLE;
         ret_state  <= ST_ALIGN;
         tap        <= '0;
         slip_cnt   <= '0;
         settle_cnt <= '0;
         tap_good   <= 1'b0;
         at_center  <= 1'b0;
         cur_start  <= '0;
         cur_len    <= '0;
         best_start <= '0;
         best_len   <= '0;
         pat_sel    <= PAT_OFF;
         dly_val    <= '0;
         dly_ld     <= 1'b0;
         bitslip    <= 1'b0;
         busy       <= 1'b0;
         locked     <= 1'b0;
         fail       <= 1'b0;
         tap_out    <= '0;
      end else begin
         dly_ld  <= 1'b0;
         bitslip <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
               if (bus.start_i) begin
                  pat_sel    <= PAT_ALT;
                  tap        <= '0;
                  busy       <= 1'b1;
                  locked     <= 1'b0;
                  fail       <= 1'b0;
                  at_center  <= 1'b0;
                  cur_start  <= '0;
                  cur_len    <= '0;
                  best_start <= '0;
                  best_len   <= '0;
                  state      <= ST_TAP_LD;
               end
            end
            ST_TAP_LD: begin
               dly_val    <= tap;
               dly_ld     <= 1'b1;
               slip_cnt   <= '0;
               settle_cnt <= '0;
               ret_state  <= ST_ALIGN;
               state      <= ST_SETTLE_W;
            end
            ST_SETTLE_W: begin
               if (settle_cnt == TW'(SETTLE - 1))
                  state <= ret_state;
               else
                  settle_cnt <= settle_cnt + TW'(1);
            end
            ST_ALIGN: begin
               if (pass_all) begin
                  if (at_center) begin
                     pat_sel    <= PAT_RAMP;
                     settle_cnt <= '0;
                     ret_state  <= ST_RAMP_CHK;
                     state      <= ST_SETTLE_W;
                  end else begin
                     tap_good <= 1'b1;
                     state    <= ST_SCAN_CHK;
                  end
               end else if (err_any) begin
                  bitslip    <= 1'b1;
                  slip_cnt   <= slip_cnt + SW'(1);
                  settle_cnt <= '0;
                  ret_state  <= ST_ALIGN;
                  if (slip_cnt == SW'(SLIP_N - 1)) begin
                     if (at_center) begin
                        pat_sel <= PAT_OFF;
                        fail    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_FAIL;
                     end else begin
                        tap_good <= 1'b0;
                        state    <= ST_SCAN_CHK;
                     end
                  end else begin
                     state <= ST_SETTLE_W;
                  end
               end
            end
            ST_SCAN_CHK: begin
               cur_len    <= scan_len;
               cur_start  <= scan_start;
               best_len   <= fin_len;
               best_start <= fin_start;
               if (tap == TAP_MAX) begin
                  state <= ST_CENTER;
               end else begin
                  tap   <= tap + DLY_W'(1);
                  state <= ST_TAP_LD;
               end
            end
            ST_CENTER: begin
               if (best_len == '0) begin
                  pat_sel <= PAT_OFF;
                  fail    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= ST_FAIL;
               end else begin
                  tap       <= center_tap;
                  at_center <= 1'b1;
                  state     <= ST_TAP_LD;
               end
            end
            ST_RAMP_CHK: begin
               if (pass_all) begin
                  pat_sel <= PAT_OFF;
                  tap_out <= tap;
                  locked  <= 1'b1;
                  busy    <= 1'b0;
                  state   <= ST_DONE;
               end else if (err_any) begin
                  pat_sel <= PAT_OFF;
                  fail    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= ST_FAIL;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.pat_sel_o = pat_sel;
   assign bus.bitslip_o = bitslip;
   assign bus.dly_ld_o  = dly_ld;
   assign bus.dly_val_o = dly_val;
   assign bus.busy_o    = busy;
   assign bus.locked_o  = locked;
   assign bus.fail_o    = fail;
   assign bus.tap_o     = tap_out;
   assign bus.dbg_state = state;

endmodule
